// File: rtl/display_scanner_pkg.sv
// Shared types and constants for the seven-segment display scanner.
package display_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;

  localparam logic [DIGITS-1:0] AN_ALL_OFF = 4'b1111;
  localparam logic [DIGITS-1:0] SEL_FIRST  = 4'b0001;

  function automatic logic [DIGITS-1:0] rotl_sel(input logic [DIGITS-1:0] sel);
    return {sel[DIGITS-2:0], sel[DIGITS-1]};
  endfunction

endpackage

// File: rtl/display_scanner_selector.sv
// 4-way nibble selector: picks the nibble addressed by a one-hot select.
module selector
  import display_scanner_pkg::*;
(
  input  logic [DIGITS-1:0]          sel_i,
  input  logic [DIGITS*NIBBLE_W-1:0] n_i,
  output logic [NIBBLE_W-1:0]        h_o
);

  // One-hot select to nibble; an illegal select yields zero.
  always_comb begin
    h_o = 4'h0;
    case (sel_i)
      4'b0001: h_o = n_i[3:0];
      4'b0010: h_o = n_i[7:4];
      4'b0100: h_o = n_i[11:8];
      4'b1000: h_o = n_i[15:12];
      default: h_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Four-digit display scan controller: blanked digit slots, one-hot select,
// active-low anodes and a per-frame snapshot of the display value.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic [15:0]            value_i,
  input  logic [DIGITS-1:0]      digit_en_i,
  output logic [DIGITS-1:0]      sel_o,
  output logic [DIGITS-1:0]      an_o,
  output logic [NIBBLE_W-1:0]    hex_o,
  output logic                   frame_o
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam state_e SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  state_e               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DIGITS-1:0]    r_sel;
  logic [DIGITS-1:0]    r_an;
  logic                 r_frame;
  logic [15:0]          r_shadow;

  state_e               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [DIGITS-1:0]    w_sel_nxt;
  logic [DIGITS-1:0]    w_an_nxt;
  logic                 w_frame_nxt;
  logic [15:0]          w_shadow_nxt;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State, slot counter, select, anodes and shadow register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sel    <= SEL_FIRST;
      r_an     <= AN_ALL_OFF;
      r_frame  <= 1'b0;
      r_shadow <= 16'h0000;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_an     <= w_an_nxt;
      r_frame  <= w_frame_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  // Next-state logic: disable wins over slot advance and frame wrap.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_frame_nxt  = 1'b0;
    w_shadow_nxt = r_shadow;
    if (!en_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_sel_nxt   = SEL_FIRST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = SLOT_START;
          w_cnt_nxt    = '0;
          w_sel_nxt    = SEL_FIRST;
          w_shadow_nxt = value_i;
          w_frame_nxt  = 1'b1;
        end
        ST_BLANK, ST_SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_sel_nxt   = rotl_sel(r_sel);
            w_state_nxt = SLOT_START;
            // Leaving the last digit starts a new frame: snapshot the value.
            if (r_sel[DIGITS-1]) begin
              w_shadow_nxt = value_i;
              w_frame_nxt  = 1'b1;
            end else begin
              w_shadow_nxt = r_shadow;
              w_frame_nxt  = 1'b0;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if ((r_state == ST_BLANK) && (w_cnt_inc == CNT_SHOW)) begin
              w_state_nxt = ST_SHOW;
            end else begin
              w_state_nxt = r_state;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_sel_nxt   = SEL_FIRST;
        end
      endcase
    end
  end

  // Anodes track the upcoming select so both change on the same edge.
  always_comb begin
    if (w_state_nxt == ST_SHOW) begin
      w_an_nxt = ~(w_sel_nxt & digit_en_i);
    end else begin
      w_an_nxt = AN_ALL_OFF;
    end
  end

  selector u_selector (
    .sel_i (r_sel),
    .n_i   (r_shadow),
    .h_o   (hex_o)
  );

  assign sel_o   = r_sel;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing controller for the four-digit seven-segment display. It generates the one-hot digit select that drives the existing 4-way nibble selector and the active-low anode enables. It inserts a blanking gap between digits to suppress ghosting, and snapshots the 16-bit display value once per frame so a refresh never shows a torn value. It sits between the game core's score/value register and the hex-to-segment decoder.

## Interface
- DIGIT_CYCLES, 100000, clocks per digit slot (1 ms at 100 MHz); legal range ≥ 2
- BLANK_CYCLES, 1000, clocks at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < DIGIT_CYCLES
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- en_i  in  1  scan enable; low holds the display dark
- value_i  in  16  display value, digit 0 = value_i[3:0], digit 3 = value_i[15:12]
- digit_en_i  in  4  per-digit enable mask (bit n = digit n), sampled live
- sel_o  out  4  one-hot digit select, registered
- an_o  out  4  active-low anode enables, registered
- hex_o  out  4  nibble of the shadow value for the current digit, combinational from sel_o and the shadow register
- frame_o  out  1  one-cycle pulse when the shadow register loads

## Operation
- There are three states:
  - IDLE: display off.
  - BLANK: slot active, anodes off.
  - SHOW: slot active, one anode on.
- Reset, applied on any cycle including mid-slot, sets the following on the next edge:
  - state = IDLE, sel_o = 4'b0001, an_o = 4'b1111, frame_o = 0, shadow = 16'h0000, slot counter = 0.
- IDLE:
  - Outputs are held at their reset values.
  - On the edge where en_i = 1: load shadow ← value_i, frame_o = 1 next cycle, counter = 0, sel_o = 0001.
  - Next state is BLANK, or SHOW if BLANK_CYCLES = 0.
- Slot counter:
  - Counts 0 … DIGIT_CYCLES−1 in both BLANK and SHOW.
  - BLANK → SHOW on the edge where the counter reaches BLANK_CYCLES.
- End of slot (counter = DIGIT_CYCLES−1):
  - Counter returns to 0.
  - sel_o rotates left: 0001→0010→0100→1000→0001.
  - Next state is BLANK, or SHOW if BLANK_CYCLES = 0.
- Frame wrap (sel_o 1000→0001):
  - Shadow ← value_i and frame_o pulses for one cycle.
  - There is no other shadow load point; value_i changes mid-frame are invisible until the next wrap.
- an_o:
  - In SHOW: an_o = ~(next sel_o & digit_en_i).
  - In BLANK/IDLE: an_o = 1111.
  - A masked digit stays dark but still consumes its full slot.
- en_i low in BLANK or SHOW: next edge goes to IDLE with reset-value outputs. Shadow is kept but is reloaded on re-enable.
- Simultaneous events: reset_i has priority over en_i. en_i low has priority over slot advance and frame wrap. The frame_o pulse is suppressed if en_i is low on the wrap edge.

## Timing
- Enable latency: en_i sampled high at edge k → frame_o = 1 and sel_o = 0001 during cycle k+1. With the default BLANK_CYCLES > 0, the first anode goes low BLANK_CYCLES cycles later.
- Period: each digit is held DIGIT_CYCLES cycles, of which DIGIT_CYCLES−BLANK_CYCLES are lit. A frame is 4·DIGIT_CYCLES cycles, so frame_o pulses are exactly 4·DIGIT_CYCLES apart while enabled.
- hex_o settles in the same cycle as sel_o; there is no extra pipeline stage.
- sel_o and an_o change on the same edge. The blank interval separates any anode turn-on from the preceding sel_o change.
- Counter width is $clog2(DIGIT_CYCLES). The counter never exceeds DIGIT_CYCLES−1.

## Structure
- The shared display package holds:
  - state enum (IDLE, BLANK, SHOW)
  - DIGITS = 4, NIBBLE_W = 4
  - the all-anodes-off constant 4'b1111
- Sub-module: one instance of the existing `selector` (sel_i = sel_o, n_i = shadow, h_o = hex_o).
- The FSM, counter, rotation and shadow register stay in this module.

## Test plan
All scenarios use DIGIT_CYCLES = 4 and BLANK_CYCLES = 1 unless noted.
- Reset then idle: reset_i high 2 cycles, en_i = 0 → sel_o = 0001, an_o = 1111, frame_o = 0, hex_o = 0, held indefinitely.
- Basic scan: value_i = 16'hA5C3, digit_en_i = 1111, en_i high at edge 0:
  - frame_o high in cycle 1.
  - an_o = 1111 in cycle 1, then 1110 in cycles 2–4 with hex_o = 3.
  - Digit 1 runs cycles 5–8: blank, then 1101 with hex_o = C.
  - Next frame_o is in cycle 17.
- Tear-free: change value_i to 16'h1234 while digit 1 is shown → hex_o shows A5C3 nibbles until the frame wrap, then 4, 3, 2, 1 after frame_o.
- Mask: digit_en_i = 0101 → an_o is only ever 1111, 1110 or 1011; slot timing is unchanged.
- Mid-slot disable and reset: en_i low during a SHOW of digit 2 → next cycle an_o = 1111 and sel_o = 0001. Re-enable → frame_o pulses and the scan restarts at digit 0. Repeat with reset_i instead of en_i; result is identical.
- No blank: BLANK_CYCLES = 0 → no all-off cycle between digits; an_o goes 1110→1101 on one edge.
